gb_interrupt_ctrl: RTL and testbench

Interrupt controller that drives the interrupt inputs of the CPU control unit. It latches the five Game Boy interrupt sources into IF (0xFF0F) and holds IE (0xFFFF) and the IME flag, including the one-instruction EI delay. It produces int_pending (dispatch request) and int_wake (HALT exit). On dispatch acknowledge it selects the highest-priority vector and clears the serviced IF bit.

---
 rtl/gb_interrupt_ctrl.sv | 139 +++++++++++++
 tb/tb_gb_interrupt_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gb_interrupt_ctrl.sv
// rtl/gb_interrupt_ctrl.sv - Game Boy interrupt controller: IF/IE/IME, EI delay, vectoring
// Optional dispatch counter enabled by INT_CTRL_DISPATCH_CNT_EN.
module gb_interrupt_ctrl #(
  parameter int         NUM_SRC    = 5,
  parameter logic [7:0] VEC_BASE   = 8'h40,
  parameter logic [7:0] VEC_STRIDE = 8'h08
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [15:0]        addr,
  input  logic [7:0]         data_in,
  input  logic               wr_en,
  output logic [7:0]         data_out,
  input  logic               ei_exec,
  input  logic               di_exec,
  input  logic               reti_exec,
  input  logic               inst_done,
  input  logic               int_ack,
  output logic               int_pending,
  output logic               int_wake,
  output logic [7:0]         vector,
  output logic [15:0]        dispatch_count
);

  typedef enum logic {EI_IDLE, EI_ARMED} ei_state_e;

  logic [NUM_SRC-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic               ime_q, ime_d;
  ei_state_e          ei_state_q, ei_state_d;
  logic [7:0]         vector_q, vector_d;
  logic [NUM_SRC-1:0] irq_hist_q, irq_hist_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] clr_mask;
  logic [7:0]         sel_idx;
  logic               ack_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_q       <= '0;
      ie_q       <= 8'h00;
      ime_q      <= 1'b0;
      ei_state_q <= EI_IDLE;
      vector_q   <= 8'h00;
      irq_hist_q <= '0;
    end else begin
      if_q       <= if_d;
      ie_q       <= ie_d;
      ime_q      <= ime_d;
      ei_state_q <= ei_state_d;
      vector_q   <= vector_d;
      irq_hist_q <= irq_hist_d;
    end
  end

  always_comb begin
    rise       = irq_src & ~irq_hist_q;
    irq_hist_d = irq_src;
    pend       = if_q & ie_q[NUM_SRC-1:0];
    ack_valid  = |pend;

    // Descending scan so the lowest set bit (highest priority) is the one kept.
    sel_idx  = 8'h00;
    clr_mask = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_idx     = 8'(i);
        clr_mask    = '0;
        clr_mask[i] = 1'b1;
      end
    end

    // Write first, then hardware edges, then the acknowledge clear on top.
    if_d = if_q;
    if (wr_en && addr == 16'hFF0F) if_d = data_in[NUM_SRC-1:0];
    if_d = if_d | rise;
    if (int_ack) if_d = if_d & ~clr_mask;

    ie_d = ie_q;
    if (wr_en && addr == 16'hFFFF) ie_d = data_in;

    ime_d      = ime_q;
    ei_state_d = ei_state_q;
    case (ei_state_q)
      EI_IDLE: begin
        if (ei_exec) ei_state_d = EI_ARMED;
      end
      EI_ARMED: begin
        if (!ei_exec && inst_done) begin
          ime_d      = 1'b1;
          ei_state_d = EI_IDLE;
        end
      end
      default: ei_state_d = EI_IDLE;
    endcase

    if (int_ack || di_exec) begin
      ime_d      = 1'b0;
      ei_state_d = EI_IDLE;
    end else if (reti_exec) begin
      ime_d = 1'b1;
    end

    vector_d = vector_q;
    if (int_ack) vector_d = ack_valid ? (VEC_BASE + sel_idx * VEC_STRIDE) : 8'h00;
  end

  always_comb begin
    data_out = 8'hFF;
    if (addr == 16'hFF0F)      data_out = {{(8 - NUM_SRC){1'b1}}, if_q};
    else if (addr == 16'hFFFF) data_out = ie_q;
  end

  assign int_wake    = |(ie_q[NUM_SRC-1:0] & if_q);
  assign int_pending = ime_q & int_wake;
  assign vector      = vector_q;

`ifdef INT_CTRL_DISPATCH_CNT_EN
  logic [15:0] dispatch_cnt_q, dispatch_cnt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) dispatch_cnt_q <= 16'h0000;
    else        dispatch_cnt_q <= dispatch_cnt_d;
  end

  always_comb begin
    dispatch_cnt_d = dispatch_cnt_q;
    if (int_ack && ack_valid) dispatch_cnt_d = dispatch_cnt_q + 16'd1;
  end

  assign dispatch_count = dispatch_cnt_q;
`else
  assign dispatch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
// tb/tb_gb_interrupt_ctrl.sv - directed self-checking bench for gb_interrupt_ctrl
module tb_gb_interrupt_ctrl;

  logic        clock;
  logic        reset;
  logic [4:0]  irq_src;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        wr_en;
  logic [7:0]  data_out;
  logic        ei_exec;
  logic        di_exec;
  logic        reti_exec;
  logic        inst_done;
  logic        int_ack;
  logic        int_pending;
  logic        int_wake;
  logic [7:0]  vector;
  logic [15:0] dispatch_count;

  int tests;
  int fails;

  gb_interrupt_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .irq_src        (irq_src),
    .addr           (addr),
    .data_in        (data_in),
    .wr_en          (wr_en),
    .data_out       (data_out),
    .ei_exec        (ei_exec),
    .di_exec        (di_exec),
    .reti_exec      (reti_exec),
    .inst_done      (inst_done),
    .int_ack        (int_ack),
    .int_pending    (int_pending),
    .int_wake       (int_wake),
    .vector         (vector),
    .dispatch_count (dispatch_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    wr_en     = 1'b0;
    ei_exec   = 1'b0;
    di_exec   = 1'b0;
    reti_exec = 1'b0;
    inst_done = 1'b0;
    int_ack   = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr    = a;
    data_in = d;
    wr_en   = 1'b1;
    tick();
  endtask

  task automatic rd(input string name, input logic [15:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check(name, {8'h00, data_out}, {8'h00, exp});
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    clock     = 1'b0;
    reset     = 1'b0;
    irq_src   = 5'b00000;
    addr      = 16'h0000;
    data_in   = 8'h00;
    wr_en     = 1'b0;
    ei_exec   = 1'b0;
    di_exec   = 1'b0;
    reti_exec = 1'b0;
    inst_done = 1'b0;
    int_ack   = 1'b0;

    #2;
    check("rst_pending", {15'd0, int_pending}, 16'h0000);
    check("rst_wake", {15'd0, int_wake}, 16'h0000);
    check("rst_vector", {8'h00, vector}, 16'h0000);
    check("rst_count", dispatch_count, 16'h0000);
    rd("rst_if", 16'hFF0F, 8'hE0);
    rd("rst_ie", 16'hFFFF, 8'h00);
    rd("other_addr", 16'hC000, 8'hFF);

    @(posedge clock);
    #1;
    reset = 1'b1;
    tick();

    // 1: EI delay then VBlank edge
    wr(16'hFFFF, 8'h01);
    wr(16'hFF0F, 8'h00);
    ei_exec = 1'b1;
    tick();
    tick();
    tick();
    inst_done = 1'b1;
    tick();
    check("t1_pending_no_if", {15'd0, int_pending}, 16'h0000);
    irq_src = 5'b00001;
    tick();
    rd("t1_if", 16'hFF0F, 8'hE1);
    check("t1_pending", {15'd0, int_pending}, 16'h0001);

    // 2: simultaneous Timer + Joypad, priority vectoring
    irq_src = 5'b00000;
    wr(16'hFF0F, 8'h00);
    wr(16'hFFFF, 8'h1F);
    irq_src = 5'b10100;
    tick();
    check("t2_pending_before", {15'd0, int_pending}, 16'h0001);
    int_ack = 1'b1;
    tick();
    check("t2_vector1", {8'h00, vector}, 16'h0050);
    rd("t2_if1", 16'hFF0F, 8'hF0);
    check("t2_pending_after", {15'd0, int_pending}, 16'h0000);
    reti_exec = 1'b1;
    tick();
    check("t2_pending_reti", {15'd0, int_pending}, 16'h0001);
    int_ack = 1'b1;
    tick();
    check("t2_vector2", {8'h00, vector}, 16'h0060);
    rd("t2_if2", 16'hFF0F, 8'hE0);

    // 3: wake without IME
    wr(16'hFFFF, 8'h04);
    irq_src = 5'b00000;
    tick();
    irq_src = 5'b00100;
    tick();
    check("t3_wake", {15'd0, int_wake}, 16'h0001);
    check("t3_pending", {15'd0, int_pending}, 16'h0000);
    wr(16'hFF0F, 8'h00);
    check("t3_wake_cleared", {15'd0, int_wake}, 16'h0000);

    // 4: DI cancels armed EI; EI with same-cycle inst_done does not count
    irq_src = 5'b00000;
    wr(16'hFF0F, 8'h04);
    ei_exec = 1'b1;
    tick();
    di_exec = 1'b1;
    tick();
    inst_done = 1'b1;
    tick();
    check("t4_di_cancel", {15'd0, int_pending}, 16'h0000);
    ei_exec   = 1'b1;
    inst_done = 1'b1;
    tick();
    check("t4_same_cycle", {15'd0, int_pending}, 16'h0000);
    inst_done = 1'b1;
    tick();
    check("t4_later_done", {15'd0, int_pending}, 16'h0001);

    // 5: hardware set beats write; held level does not re-set
    irq_src = 5'b01000;
    wr(16'hFF0F, 8'h00);
    rd("t5_set_wins", 16'hFF0F, 8'hE8);
    wr(16'hFF0F, 8'h00);
    for (int i = 0; i < 10; i++) tick();
    rd("t5_level_held", 16'hFF0F, 8'hE0);

    // 6: asynchronous reset mid-sequence
    irq_src = 5'b00000;
    wr(16'hFFFF, 8'h1F);
    wr(16'hFF0F, 8'h1F);
    ei_exec = 1'b1;
    tick();
    check("t6_pre_pending", {15'd0, int_pending}, 16'h0001);
    #2;
    reset = 1'b0;
    #1;
    check("t6_pending", {15'd0, int_pending}, 16'h0000);
    check("t6_wake", {15'd0, int_wake}, 16'h0000);
    check("t6_vector", {8'h00, vector}, 16'h0000);
    check("t6_count", dispatch_count, 16'h0000);
    rd("t6_if", 16'hFF0F, 8'hE0);
    rd("t6_ie", 16'hFFFF, 8'h00);
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick();

`ifdef INT_CTRL_DISPATCH_CNT_EN
    wr(16'hFFFF, 8'h1F);
    wr(16'hFF0F, 8'h1F);
    addr    = 16'hFF0F;
    data_in = 8'h1F;
    wr_en   = 1'b1;
    int_ack = 1'b1;
    for (int i = 0; i < 65537; i++) @(posedge clock);
    #1;
    wr_en   = 1'b0;
    int_ack = 1'b0;
    check("t6_count_wrap", dispatch_count, 16'h0001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
